// File: rtl/rand_mem_pkg.sv
// Shared types and constants for the random memory responder.
package rand_mem_pkg;

  typedef enum logic [1:0] {
    PH_WAIT = 2'd0,
    PH_INIT = 2'd1,
    PH_RUN  = 2'd2,
    PH_DONE = 2'd3
  } phase_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  F7_ALT    = 7'b0100000;

  // Indexed by a raw 3-bit draw; entries wrap so every index is legal.
  localparam logic [2:0] LOAD_F3 [0:7] = '{
    3'b000, 3'b001, 3'b010, 3'b100,
    3'b101, 3'b000, 3'b001, 3'b010
  };
  localparam logic [2:0] STORE_F3 [0:7] = '{
    3'b000, 3'b001, 3'b010, 3'b000,
    3'b001, 3'b010, 3'b000, 3'b001
  };
  localparam logic [2:0] BR_F3 [0:7] = '{
    3'b000, 3'b001, 3'b100, 3'b101,
    3'b110, 3'b111, 3'b000, 3'b001
  };

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// RV32I base opcodes shared by the pipeline and its bench models.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

endpackage

// File: rtl/rand_instr_gen.sv
// Maps an LFSR word, phase and init index to one RV32I instruction.
module rand_instr_gen
  import rv32i_types::*;
  import rand_mem_pkg::*;
(
  input  logic [31:0] i_lfsr,
  input  phase_t      i_phase,
  input  logic [4:0]  i_k,
  output logic [31:0] o_instr
);

  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm_op;
  logic [31:0] w_run;

  always_comb begin
    w_f3  = i_lfsr[6:4];
    w_rd  = i_lfsr[11:7];
    w_rs1 = i_lfsr[19:15];
    w_rs2 = i_lfsr[24:20];
    w_f7  = 7'd0;
    if (i_lfsr[31] && (w_f3 == 3'b000 || w_f3 == 3'b101))
      w_f7 = F7_ALT;
    unique case (w_f3)
      3'b001:
        w_imm_op = {7'd0, w_rs2, w_rs1, w_f3, w_rd, op_imm};
      3'b101:
        w_imm_op = {w_f7, w_rs2, w_rs1, w_f3, w_rd, op_imm};
      default:
        w_imm_op = {i_lfsr[31:20], w_rs1, w_f3, w_rd, op_imm};
    endcase
  end

  always_comb begin
    w_run = w_imm_op;
    unique case (i_lfsr[3:0])
      4'd0: w_run = {i_lfsr[31:12], w_rd, op_lui};
      4'd1: w_run = {i_lfsr[31:12], w_rd, op_auipc};
      4'd2: w_run = {w_f7, w_rs2, w_rs1, w_f3, w_rd, op_reg};
      4'd4: w_run = {i_lfsr[31:20], w_rs1,
                     LOAD_F3[w_f3], w_rd, op_load};
      4'd5: w_run = {i_lfsr[31:25], w_rs2, w_rs1,
                     STORE_F3[w_f3], w_rd, op_store};
      4'd6: w_run = {i_lfsr[31:25], w_rs2, w_rs1,
                     BR_F3[w_f3], w_rd, op_br};
      4'd7: w_run = {i_lfsr[31:12], w_rd, op_jal};
      4'd8: w_run = {i_lfsr[31:20], w_rs1,
                     3'b000, w_rd, op_jalr};
      default: w_run = w_imm_op;
    endcase
  end

  always_comb begin
    unique case (i_phase)
      PH_INIT: o_instr = {i_lfsr[31:12], i_k, op_lui};
      PH_RUN:  o_instr = w_run;
      default: o_instr = NOP;
    endcase
  end

endmodule

// File: rtl/rand_mem_responder.sv
// Random-stimulus memory responder: per-port latency/stall handshakes
// and a WAIT/INIT/RUN/DONE instruction-stream sequencer.
module rand_mem_responder
  import rand_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned LATENCY    = 1,
  parameter bit          RAND_STALL = 1'b0,
  parameter int unsigned NUM_INSTRS = 60000,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr  [NUM_PORTS],
  input  logic [3:0]  rmask [NUM_PORTS],
  input  logic [3:0]  wmask [NUM_PORTS],
  input  logic [31:0] wdata [NUM_PORTS],
  output logic [31:0] rdata [NUM_PORTS],
  output logic        resp  [NUM_PORTS],
  output logic [1:0]  phase,
  output logic        done
);

  localparam logic [4:0]  LAT      = 5'(LATENCY);
  localparam logic [16:0] RUN_LAST = 17'(NUM_INSTRS - 1);

  phase_t      r_phase;
  logic        r_wcnt;
  logic [4:0]  r_k;
  logic [16:0] r_run;
  logic        r_done;
  logic        w_go;
  logic [31:0] w_lfsr0;
  logic [31:0] w_instr;
  logic        w_p0_rd_done;

  // Countdowns are frozen in WAIT so early requests are held.
  assign w_go  = (r_phase != PH_WAIT);
  assign phase = r_phase;
  assign done  = r_done;

  rand_instr_gen u_gen (
    .i_lfsr  (w_lfsr0),
    .i_phase (r_phase),
    .i_k     (r_k),
    .o_instr (w_instr)
  );

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [31:0] r_lfsr;
    logic [31:0] r_rdata;
    logic        r_resp;
    logic        r_is_rd;
    logic        w_req;
    logic [31:0] w_s1;
    logic [31:0] w_next;
    logic [1:0]  w_stall;
    logic [31:0] w_word;
    logic        w_unused;

    assign w_unused = ^{addr[p], wdata[p]};
    assign w_req    = |{rmask[p], wmask[p]};
    assign w_s1     = lfsr_step(r_lfsr);
    assign w_stall  = RAND_STALL ? w_s1[1:0] : 2'd0;
    assign w_next   = RAND_STALL ? lfsr_step(w_s1) : w_s1;
    assign w_word   = (p == 0 && r_is_rd) ? w_instr : r_lfsr;
    assign rdata[p] = r_rdata;
    assign resp[p]  = r_resp;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_busy  <= 1'b0;
        r_cnt   <= 5'd0;
        r_lfsr  <= SEED ^ 32'(p);
        r_rdata <= 32'd0;
        r_resp  <= 1'b0;
        r_is_rd <= 1'b0;
      end else begin
        r_resp <= 1'b0;
        if (!r_busy) begin
          if (w_req) begin
            r_busy  <= 1'b1;
            r_cnt   <= LAT + {3'd0, w_stall};
            r_lfsr  <= w_next;
            r_is_rd <= |rmask[p];
          end
        end else if (w_go) begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_busy  <= 1'b0;
            r_resp  <= 1'b1;
            r_rdata <= w_word;
          end
        end
      end
    end

    if (p == 0) begin : g_p0
      assign w_lfsr0      = r_lfsr;
      assign w_p0_rd_done = r_resp && r_is_rd;
    end
  end

  // Counting off the registered pulse puts each phase change one
  // cycle after the response that triggered it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= PH_WAIT;
      r_wcnt  <= 1'b0;
      r_k     <= 5'd0;
      r_run   <= 17'd0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_phase)
        PH_WAIT: begin
          if (r_wcnt) r_phase <= PH_INIT;
          else        r_wcnt  <= 1'b1;
        end
        PH_INIT: begin
          if (w_p0_rd_done) begin
            r_k <= r_k + 5'd1;
            if (r_k == 5'd31) r_phase <= PH_RUN;
          end
        end
        PH_RUN: begin
          if (w_p0_rd_done) begin
            if (r_run != '1) r_run <= r_run + 17'd1;
            if (r_run == RUN_LAST) begin
              r_phase <= PH_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        PH_DONE: r_done <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_mem_responder.sv
// Directed bench for rand_mem_responder: phases, latency, stalls, reset.
module tb_rand_mem_responder;

  localparam int          LAT_A = 1;
  localparam int          NI_A  = 1000;
  localparam int          LAT_B = 4;
  localparam logic [31:0] SEED  = 32'hACE1_2468;

  logic        clk;
  logic        rst_a, rst_b;
  logic [31:0] ad_a [2], wd_a [2], rd_a [2];
  logic [3:0]  rm_a [2], wm_a [2];
  logic        rs_a [2];
  logic [1:0]  ph_a;
  logic        dn_a;
  logic [31:0] ad_b [2], wd_b [2], rd_b [2];
  logic [3:0]  rm_b [2], wm_b [2];
  logic        rs_b [2];
  logic [1:0]  ph_b;
  logic        dn_b;

  int errs = 0;
  int checks = 0;

  rand_mem_responder #(
    .NUM_PORTS(2), .LATENCY(LAT_A), .RAND_STALL(1'b0),
    .NUM_INSTRS(NI_A), .SEED(SEED)
  ) u_a (
    .clk(clk), .rst(rst_a), .addr(ad_a), .rmask(rm_a),
    .wmask(wm_a), .wdata(wd_a), .rdata(rd_a), .resp(rs_a),
    .phase(ph_a), .done(dn_a)
  );

  rand_mem_responder #(
    .NUM_PORTS(2), .LATENCY(LAT_B), .RAND_STALL(1'b1),
    .NUM_INSTRS(10), .SEED(SEED)
  ) u_b (
    .clk(clk), .rst(rst_b), .addr(ad_b), .rmask(rm_b),
    .wmask(wm_b), .wdata(wd_b), .rdata(rd_b), .resp(rs_b),
    .phase(ph_b), .done(dn_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] lui(input logic [31:0] l,
                                      input int k);
    logic [4:0] kk;
    kk = 5'(k);
    return {l[31:12], kk, 7'b0110111};
  endfunction

  function automatic logic [6:0] exp_op(input logic [3:0] sel);
    case (sel)
      4'd0: return 7'b0110111;
      4'd1: return 7'b0010111;
      4'd2: return 7'b0110011;
      4'd4: return 7'b0000011;
      4'd5: return 7'b0100011;
      4'd6: return 7'b1100011;
      4'd7: return 7'b1101111;
      4'd8: return 7'b1100111;
      default: return 7'b0010011;
    endcase
  endfunction

  function automatic logic legal(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: return 1'b1;
      7'b0110011:
        return f7 == 7'd0 ||
               (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      7'b0010011:
        if (f3 == 3'd1) return f7 == 7'd0;
        else if (f3 == 3'd5) return f7 == 7'd0 || f7 == 7'h20;
        else return 1'b1;
      7'b0000011: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'b0100011: return f3 <= 3'd2;
      7'b1100011: return f3 != 3'd2 && f3 != 3'd3;
      7'b1100111: return f3 == 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // lat = edges from presenting the request until resp is seen,
  // i.e. the accept edge plus the countdown.
  task automatic xact_a(input int p, input logic [3:0] rm,
                        input logic [3:0] wm, output int lat,
                        output logic [31:0] d, output logic ra,
                        output logic [1:0] ph, output logic dn);
    lat = 0;
    d = '0;
    rm_a[p] = rm;
    wm_a[p] = wm;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rs_a[p]) begin
        lat = i;
        d = rd_a[p];
        break;
      end
    end
    rm_a[p] = 4'd0;
    wm_a[p] = 4'd0;
    @(posedge clk); #1;
    ra = rs_a[p];
    ph = ph_a;
    dn = dn_a;
  endtask

  task automatic xact_b(input int p, output int lat,
                        output logic [31:0] d, output logic ra);
    lat = 0;
    d = '0;
    rm_b[p] = 4'hF;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rs_b[p]) begin
        lat = i;
        d = rd_b[p];
        break;
      end
    end
    rm_b[p] = 4'd0;
    @(posedge clk); #1;
    ra = rs_b[p];
  endtask

  typedef struct {
    int          port;
    logic [3:0]  rm;
    logic [3:0]  wm;
    int          lat;
    logic        chkd;
    logic [31:0] data;
    logic [1:0]  ph;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [31:0] m0, m1, n0, n1, a0, a1, d, d0, d1;
    logic        ra, ra0, ra1, dn;
    logic [1:0]  ph;
    int          lat, l0, l1, e0, e1, kb;

    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int p = 0; p < 2; p++) begin
      ad_a[p] = 32'h100 * p; wd_a[p] = 32'hDEAD_0000 + p;
      rm_a[p] = 4'd0; wm_a[p] = 4'd0;
      ad_b[p] = 32'h200 * p; wd_b[p] = 32'hBEEF_0000 + p;
      rm_b[p] = 4'd0; wm_b[p] = 4'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata0", rd_a[0], 32'd0);
    chk("reset_resp", {31'd0, rs_a[0] | rs_a[1]}, 32'd0);
    chk("reset_phase", {30'd0, ph_a}, 32'd0);
    chk("reset_done", {31'd0, dn_a}, 32'd0);

    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    chk("wait_phase", {30'd0, ph_a}, 32'd0);
    xact_a(0, 4'hF, 4'h0, lat, d, ra, ph, dn);
    m0 = step(SEED);
    m1 = SEED ^ 32'd1;
    chk("first_lat", lat, 2 + LAT_A);
    chk("first_word", d, lui(m0, 0));
    chk("first_rd", {27'd0, d[11:7]}, 32'd0);
    chk("first_phase", {30'd0, ph}, 32'd1);

    m1 = step(m1);
    vt[0] = '{1, 4'hF, 4'h0, LAT_A + 1, 1'b1, m1, 2'd1};
    m1 = step(m1);
    vt[1] = '{1, 4'h0, 4'b0011, LAT_A + 1, 1'b0, 32'd0, 2'd1};
    m0 = step(m0);
    vt[2] = '{0, 4'hF, 4'h0, LAT_A + 1, 1'b1, lui(m0, 1), 2'd1};
    m1 = step(m1);
    vt[3] = '{1, 4'h2, 4'h0, LAT_A + 1, 1'b1, m1, 2'd1};
    m0 = step(m0);
    vt[4] = '{0, 4'h0, 4'hF, LAT_A + 1, 1'b0, 32'd0, 2'd1};
    m0 = step(m0);
    vt[5] = '{0, 4'h1, 4'h0, LAT_A + 1, 1'b1, lui(m0, 2), 2'd1};

    for (int i = 0; i < 6; i++) begin
      xact_a(vt[i].port, vt[i].rm, vt[i].wm, lat, d, ra, ph, dn);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      if (vt[i].chkd) chk($sformatf("vec%0d_data", i), d, vt[i].data);
      chk($sformatf("vec%0d_pulse", i), {31'd0, ra}, 32'd0);
      chk($sformatf("vec%0d_phase", i), {30'd0, ph}, {30'd0, vt[i].ph});
    end

    for (int k = 3; k < 32; k++) begin
      xact_a(0, 4'hF, 4'h0, lat, d, ra, ph, dn);
      m0 = step(m0);
      chk($sformatf("init%0d_word", k), d, lui(m0, k));
      chk($sformatf("init%0d_phase", k), {30'd0, ph},
          (k == 31) ? 32'd2 : 32'd1);
    end

    for (int i = 0; i < NI_A; i++) begin
      xact_a(0, 4'hF, 4'h0, lat, d, ra, ph, dn);
      m0 = step(m0);
      chk($sformatf("run%0d_op", i), {24'd0, legal(d), d[6:0]},
          {24'd0, 1'b1, exp_op(m0[3:0])});
      chk($sformatf("run%0d_done", i), {31'd0, dn},
          (i == NI_A - 1) ? 32'd1 : 32'd0);
    end
    chk("done_phase", {30'd0, ph}, 32'd3);
    xact_a(0, 4'hF, 4'h0, lat, d, ra, ph, dn);
    chk("done_nop", d, 32'h0000_0013);
    chk("done_sticky", {31'd0, dn}, 32'd1);

    rm_a[0] = 4'hF;
    @(posedge clk); #2;
    rst_a = 1'b0;
    rm_a[0] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_resp", {31'd0, rs_a[0]}, 32'd0);
      chk("abort_out", {rd_a[0][28:0], ph_a, dn_a}, 32'd0);
    end
    @(negedge clk);
    rst_a = 1'b1;
    xact_a(0, 4'hF, 4'h0, lat, d, ra, ph, dn);
    chk("restart_lat", lat, 2 + LAT_A);
    chk("restart_word", d, lui(step(SEED), 0));

    n0 = SEED;
    n1 = SEED ^ 32'd1;
    kb = 0;
    for (int r = 0; r < 4; r++) begin
      a0 = step(n0);
      n0 = step(a0);
      e0 = 1 + LAT_B + int'(a0[1:0]);
      a1 = step(n1);
      n1 = step(a1);
      e1 = 1 + LAT_B + int'(a1[1:0]);
      fork
        xact_b(0, l0, d0, ra0);
        xact_b(1, l1, d1, ra1);
      join
      chk($sformatf("stall%0d_lat0", r), l0, e0);
      chk($sformatf("stall%0d_lat1", r), l1, e1);
      chk($sformatf("stall%0d_word0", r), d0, lui(n0, kb));
      chk($sformatf("stall%0d_word1", r), d1, n1);
      chk($sformatf("stall%0d_pulse", r), {30'd0, ra0, ra1}, 32'd0);
      kb++;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rand_mem_responder.md
# rand_mem_responder

Parametrised, synthesizable random-stimulus memory responder for the pipeline bench. It serves `NUM_PORTS` `mem_itf`-style channels: port 0 is the instruction port and ports 1..N-1 are data ports. It runs a fixed phase sequence: reset wait, a LUI register-initialisation burst, then `NUM_INSTRS` random valid RV32I instructions. Per-port latency is configurable, with optional LFSR-driven random stalls. It sits between the DUT's I/D memory ports and the top-level harness, and raises `done` for the harness to end simulation.

## Interface
- `NUM_PORTS`, 2: channel count; port 0 = instruction, ≥1 = data.
- `LATENCY`, 1: base request→resp cycles, 1..15.
- `RAND_STALL`, 0: 1 adds 0..3 extra cycles per request, taken from the port LFSR.
- `NUM_INSTRS`, 60000: port-0 read responses in the RUN phase.
- `SEED`, 32'hACE1_2468: LFSR seed; port p is seeded with `SEED ^ p`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `addr[NUM_PORTS]` in 32: request address, ignored for data.
- `rmask[NUM_PORTS]` in 4: read byte mask; nonzero = read request.
- `wmask[NUM_PORTS]` in 4: write byte mask; nonzero = write request.
- `wdata[NUM_PORTS]` in 32: write data, discarded.
- `rdata[NUM_PORTS]` out 32: read data, valid only while `resp` is high.
- `resp[NUM_PORTS]` out 1: one-cycle completion pulse.
- `phase` out 2: current FSM state.
- `done` out 1: high once RUN completes; sticky.

## Operation
- FSM states and transitions:
  - WAIT(0): 2 cycles after reset release, then → INIT.
  - INIT(1): port-0 reads return LUI rd=k with random imm; k counts 0..31. After the 32nd response → RUN.
  - RUN(2): port-0 reads return a random valid instruction. After `NUM_INSTRS` responses → DONE.
  - DONE(3): port-0 reads return `32'h0000_0013` (NOP); `done`=1.
- In WAIT, requests are accepted but held: the latency countdown does not start until INIT.
- Port handshake, per port:
  - IDLE accepts when `rmask|wmask` ≠ 0 and enters BUSY with counter = `LATENCY` + stall.
  - The counter decrements each cycle. At 0, `resp`=1 for one cycle and the port returns to IDLE.
  - A request still asserted the cycle after `resp` is treated as a new request.
  - Writes respond identically; `rdata` is driven with the LFSR word but is meaningless.
- Data-port reads return the raw 32-bit LFSR word.
- LFSR: 32-bit Galois, taps 32'h8020_0003. It steps once per accepted request and once per stall draw.
- Random instruction generation:
  - Opcode select: `sel = lfsr[3:0]` maps to lui, auipc, reg, imm, load, store, br, jal, jalr. `sel` ≥ 9 → imm.
  - load funct3 ∈ {000,001,010,100,101}, using `lfsr[6:4]` mod 5.
  - store funct3 ∈ {000,001,010}.
  - br funct3 excludes 010/011.
  - reg: funct7 = 0100000 only when funct3 ∈ {000,101} and `lfsr[31]`; otherwise 0.
  - imm: funct3 001 forces funct7=0; funct3 101 uses the same rule as reg.
  - jalr funct3 = 000.
  - Remaining fields come from LFSR bits.
- Count rule: only port-0 read responses advance k or the RUN counter. The RUN counter is 17 bits and saturates.

## Timing
- Reset values:
  - Outputs: `rdata`=0, `resp`=0, `phase`=WAIT, `done`=0.
  - Internal: all ports IDLE, counters 0, LFSRs = seed.
- Reset asserted mid-transaction aborts it: no `resp` is issued and the FSM restarts in WAIT.
- Latency: with `RAND_STALL`=0, a request seen at edge t gets `resp` high during cycle t+`LATENCY`.
- `rdata` is registered and changes only on the `resp` cycle; it holds its value otherwise.
- Simultaneous requests on several ports are fully independent; there is no arbitration.
- A phase transition takes effect on the cycle after the triggering response. That response still uses the old-phase data.

## Structure
- `rand_mem_pkg`:
  - `phase_t` enum.
  - LFSR polynomial constant.
  - NOP constant.
  - Legal funct3 lookup constants.
- Opcodes are reused from `rv32i_types`.
- Sub-module `rand_instr_gen`: combinational. Maps LFSR word + phase + k to a 32-bit instruction.
- Per-port handshake/LFSR logic lives in a generate loop in the top module.

## Test plan
- Reset release, one port-0 read held → no `resp` during WAIT; first `resp` is at cycle 2+`LATENCY`; rdata[6:0]=7'b0110111, rd=0.
- 32 back-to-back port-0 reads → rd fields 0..31 in order; `phase` becomes RUN on the cycle after the 32nd `resp`.
- RUN with `NUM_INSTRS`=1000: decode every word → all opcodes/funct3/funct7 legal; `done`=1 after response 1000; the next read returns 32'h00000013.
- `LATENCY`=4, `RAND_STALL`=1, concurrent reads on ports 0 and 1 → each `resp` arrives 4..7 cycles after accept, is one cycle wide, and the ports do not interact.
- Write on port 1 with `wmask`=4'b0011 → `resp` after `LATENCY`; the instruction counter is unchanged.
- `rst` low during a BUSY countdown → `resp` never fires, outputs are 0, and the sequence restarts with LUI rd=0.
